// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Request/grant/response bus between the memory port arbiter and the
// unified instruction/data memory.
//   req, we, addr, wdata, be : request and its fields, driven by the arbiter
//   gnt                      : memory accepted the request this cycle
//   rvalid, rdata            : response cycle (reads and writes), read data
// Modports: master (arbiter side), slave (memory side).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   be;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single memory port between the fetch stage (IF) and the
// memory-access stage (MA). One transaction is outstanding at a time; the
// arbiter always returns to IDLE between transactions.
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   if_req/if_addr/if_kill           : fetch request, address, flush cancel
//   if_valid/if_rdata                : one-cycle fetch response, registered data
//   ma_req/ma_we/ma_addr/ma_wdata/ma_be : load/store request and fields
//   ma_valid/ma_rdata                : one-cycle load/store done, load data
//   mem (master modport)             : memory req/gnt/rvalid bus
//   stall_f, stall_m                 : combinational pipeline stalls
// Configuration: define MEM_ARB_RR_EN for round-robin arbitration; otherwise
// MA has fixed priority.
//
// state  | meaning
// IDLE   | no transaction, arbitrate and latch the winner's fields
// F_REQ  | fetch request on the bus, waiting for gnt (kill retracts)
// F_RESP | fetch granted, waiting for rvalid (kill marks it discarded)
// M_REQ  | load/store request on the bus, waiting for gnt
// M_RESP | load/store granted, waiting for rvalid
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  input  logic                  if_kill,
  output logic                  if_valid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  ma_req,
  input  logic                  ma_we,
  input  logic [ADDR_W-1:0]     ma_addr,
  input  logic [DATA_W-1:0]     ma_wdata,
  input  logic [DATA_W/8-1:0]   ma_be,
  output logic                  ma_valid,
  output logic [DATA_W-1:0]     ma_rdata,
  mem_port_arbiter_if.master    mem,
  output logic                  stall_f,
  output logic                  stall_m
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, F_REQ, F_RESP, M_REQ, M_RESP} state_t;

  state_t              state, state_nxt;
  logic                kill_flag, kill_set;
  logic                grant_if, grant_ma;
  logic                if_done, ma_done;
  logic                if_elig, ma_elig, pick_ma;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [BE_W-1:0]     lat_be;

  // A requester whose valid pulse is high is still showing its completed
  // request; it must not win again in that cycle.
  assign if_elig = if_req & ~if_valid;
  assign ma_elig = ma_req & ~ma_valid;

`ifdef MEM_ARB_RR_EN
  logic last_grant_ma;

  assign pick_ma = ma_elig & (~if_elig | ~last_grant_ma);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        last_grant_ma <= 1'b0;
    else if (grant_ma) last_grant_ma <= 1'b1;
    else if (grant_if) last_grant_ma <= 1'b0;
  end
`else
  assign pick_ma = ma_elig;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_ma  = 1'b0;
    kill_set  = 1'b0;
    if_done   = 1'b0;
    ma_done   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_ma) begin
          grant_ma  = 1'b1;
          state_nxt = M_REQ;
        end else if (if_elig) begin
          grant_if  = 1'b1;
          state_nxt = F_REQ;
        end
      end
      F_REQ: begin
        // A kill that coincides with gnt is too late to retract: the memory
        // will respond, so take the response and discard it.
        if (mem.gnt) begin
          state_nxt = F_RESP;
          kill_set  = if_kill;
        end else if (if_kill) begin
          state_nxt = IDLE;
        end
      end
      F_RESP: begin
        if (mem.rvalid) begin
          state_nxt = IDLE;
          if_done   = ~(kill_flag | if_kill);
        end else begin
          kill_set  = if_kill;
        end
      end
      M_REQ: begin
        if (mem.gnt) state_nxt = M_RESP;
      end
      M_RESP: begin
        if (mem.rvalid) begin
          state_nxt = IDLE;
          ma_done   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 kill_flag <= 1'b0;
    else if (state_nxt == IDLE) kill_flag <= 1'b0;
    else if (kill_set)          kill_flag <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      if_valid  <= 1'b0;
      ma_valid  <= 1'b0;
      if_rdata  <= '0;
      ma_rdata  <= '0;
    end else begin
      if (grant_ma) begin
        lat_we    <= ma_we;
        lat_addr  <= ma_addr;
        lat_wdata <= ma_wdata;
        lat_be    <= ma_be;
      end else if (grant_if) begin
        lat_we    <= 1'b0;
        lat_addr  <= if_addr;
        lat_wdata <= '0;
        lat_be    <= '1;
      end
      if_valid <= if_done;
      ma_valid <= ma_done;
      if (if_done) if_rdata <= mem.rdata;
      if (ma_done) ma_rdata <= mem.rdata;
    end
  end

  assign mem.req   = (state == F_REQ) | (state == M_REQ);
  assign mem.we    = lat_we;
  assign mem.addr  = lat_addr;
  assign mem.wdata = lat_wdata;
  assign mem.be    = lat_be;

  assign stall_m = ma_req & ~ma_valid;
  assign stall_f = (if_req & ~if_valid) | stall_m;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_kill, ma_req, ma_we;
  logic [31:0] if_addr, ma_addr, ma_wdata;
  logic [3:0]  ma_be;
  logic        if_valid, ma_valid, stall_f, stall_m;
  logic [31:0] if_rdata, ma_rdata;
  logic        gnt, rvalid;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();
  assign mem_bus.gnt    = gnt;
  assign mem_bus.rvalid = rvalid;
  assign mem_bus.rdata  = rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata), .ma_be(ma_be),
    .ma_valid(ma_valid), .ma_rdata(ma_rdata),
    .mem(mem_bus),
    .stall_f(stall_f), .stall_m(stall_m)
  );

  typedef struct {
    logic ifr; logic [31:0] ia; logic ik;
    logic mr;  logic mw;        logic [31:0] maa;
    logic g;   logic rv;        logic [31:0] rd;
    logic e_req; logic [31:0] e_addr;
    logic e_ifv; logic [31:0] e_ifd;
    logic e_mav; logic [31:0] e_mad;
    logic e_sf;  logic e_sm;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(
    input logic ifr, input logic [31:0] ia, input logic ik,
    input logic mr, input logic mw, input logic [31:0] maa,
    input logic g, input logic rv, input logic [31:0] rd,
    input logic e_req, input logic [31:0] e_addr,
    input logic e_ifv, input logic [31:0] e_ifd,
    input logic e_mav, input logic [31:0] e_mad,
    input logic e_sf, input logic e_sm);
    vec_t v;
    v.ifr = ifr; v.ia = ia; v.ik = ik; v.mr = mr; v.mw = mw; v.maa = maa;
    v.g = g; v.rv = rv; v.rd = rd; v.e_req = e_req; v.e_addr = e_addr;
    v.e_ifv = e_ifv; v.e_ifd = e_ifd; v.e_mav = e_mav; v.e_mad = e_mad;
    v.e_sf = e_sf; v.e_sm = e_sm;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic ifr, input logic [31:0] ia, input logic ik,
                        input logic mr, input logic mw, input logic [31:0] maa,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic g, input logic rv, input logic [31:0] rd);
    if_req = ifr; if_addr = ia; if_kill = ik;
    ma_req = mr; ma_we = mw; ma_addr = maa; ma_wdata = wd; ma_be = be;
    gnt = g; rvalid = rv; rdata = rd;
  endtask

  task automatic idle_in();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model state (transaction level)
  bit          m_busy, m_who_ma, m_granted, m_killed, m_ifv, m_mav, m_last_ma;
  bit          n_ifv, n_mav, a_ma, a_if, take_ma;
  logic        m_we;
  logic [31:0] m_addr, m_wdata, m_ifr, m_mar;
  logic [3:0]  m_be;
  bit          if_act, ma_act, if_end, ma_end;
  logic [31:0] win_a, lose_a;
  bit          win_if;

  initial begin
    idle_in();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    settle();
    chk("rst mem_req", mem_bus.req, 0);
    chk("rst mem_addr", mem_bus.addr, 0);
    chk("rst if_valid", if_valid, 0);
    chk("rst ma_valid", ma_valid, 0);
    chk("rst if_rdata", if_rdata, 0);
    chk("rst ma_rdata", ma_rdata, 0);
    chk("rst stall_f", stall_f, 0);
    chk("rst stall_m", stall_m, 0);
    tick();
    rst_n = 1'b1;

    // single fetch, then simultaneous IF+MA (MA wins in both modes: last grant was IF)
    tbl[0]  = mk(1,'h100,0, 0,0,0,      0,0,0,           0,0,      0,0,           0,0,           1,0);
    tbl[1]  = mk(1,'h100,0, 0,0,0,      1,0,0,           1,'h100,  0,0,           0,0,           1,0);
    tbl[2]  = mk(1,'h100,0, 0,0,0,      0,1,'h00500093,  0,0,      0,0,           0,0,           1,0);
    tbl[3]  = mk(1,'h100,0, 0,0,0,      0,0,0,           0,0,      1,'h00500093,  0,0,           0,0);
    tbl[4]  = mk(0,0,0,     0,0,0,      0,0,0,           0,0,      0,'h00500093,  0,0,           0,0);
    tbl[5]  = mk(1,'h104,0, 1,0,'h2000, 0,0,0,           0,0,      0,'h00500093,  0,0,           1,1);
    tbl[6]  = mk(1,'h104,0, 1,0,'h2000, 1,0,0,           1,'h2000, 0,'h00500093,  0,0,           1,1);
    tbl[7]  = mk(1,'h104,0, 1,0,'h2000, 0,1,'h11112222,  0,0,      0,'h00500093,  0,0,           1,1);
    tbl[8]  = mk(1,'h104,0, 1,0,'h2000, 0,0,0,           0,0,      0,'h00500093,  1,'h11112222,  1,0);
    tbl[9]  = mk(1,'h104,0, 0,0,0,      1,0,0,           1,'h104,  0,'h00500093,  0,'h11112222,  1,0);
    tbl[10] = mk(1,'h104,0, 0,0,0,      0,1,'h22223333,  0,0,      0,'h00500093,  0,'h11112222,  1,0);
    tbl[11] = mk(1,'h104,0, 0,0,0,      0,0,0,           0,0,      1,'h22223333,  0,'h11112222,  0,0);
    tbl[12] = mk(0,0,0,     0,0,0,      0,0,0,           0,0,      0,'h22223333,  0,'h11112222,  0,0);

    for (int i = 0; i < 13; i++) begin
      set_in(tbl[i].ifr, tbl[i].ia, tbl[i].ik, tbl[i].mr, tbl[i].mw, tbl[i].maa,
             32'h0, 4'hf, tbl[i].g, tbl[i].rv, tbl[i].rd);
      settle();
      chk($sformatf("t%0d mem_req", i), mem_bus.req, tbl[i].e_req);
      if (tbl[i].e_req) chk($sformatf("t%0d mem_addr", i), mem_bus.addr, tbl[i].e_addr);
      chk($sformatf("t%0d if_valid", i), if_valid, tbl[i].e_ifv);
      chk($sformatf("t%0d if_rdata", i), if_rdata, tbl[i].e_ifd);
      chk($sformatf("t%0d ma_valid", i), ma_valid, tbl[i].e_mav);
      chk($sformatf("t%0d ma_rdata", i), ma_rdata, tbl[i].e_mad);
      chk($sformatf("t%0d stall_f", i), stall_f, tbl[i].e_sf);
      chk($sformatf("t%0d stall_m", i), stall_m, tbl[i].e_sm);
      tick();
    end

    // store with gnt delayed 3 cycles
    set_in(0,0,0, 1,1,'h3000,'hDEADBEEF,4'b0011, 0,0,0);
    settle();
    chk("st idle mem_req", mem_bus.req, 0);
    chk("st idle stall_m", stall_m, 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      set_in(0,0,0, 1,1,'h3000,'hDEADBEEF,4'b0011, (k == 3),0,0);
      settle();
      chk($sformatf("st req%0d mem_req", k), mem_bus.req, 1);
      chk($sformatf("st req%0d we", k), mem_bus.we, 1);
      chk($sformatf("st req%0d addr", k), mem_bus.addr, 'h3000);
      chk($sformatf("st req%0d wdata", k), mem_bus.wdata, 'hDEADBEEF);
      chk($sformatf("st req%0d be", k), mem_bus.be, 4'b0011);
      tick();
    end
    set_in(0,0,0, 1,1,'h3000,'hDEADBEEF,4'b0011, 0,1,'h00005A5A);
    settle();
    chk("st resp mem_req", mem_bus.req, 0);
    chk("st resp ma_valid", ma_valid, 0);
    chk("st resp stall_m", stall_m, 1);
    tick();
    set_in(0,0,0, 1,1,'h3000,'hDEADBEEF,4'b0011, 0,0,0);
    settle();
    chk("st done ma_valid", ma_valid, 1);
    chk("st done ma_rdata", ma_rdata, 'h00005A5A);
    chk("st done stall_m", stall_m, 0);
    tick();
    idle_in();
    settle();
    chk("st after ma_valid", ma_valid, 0);
    chk("st after mem_req", mem_bus.req, 0);
    tick();

    // kill in F_RESP, rvalid two cycles later
    set_in(1,'h200,0, 0,0,0,0,0, 0,0,0); settle(); tick();
    set_in(1,'h200,0, 0,0,0,0,0, 1,0,0); settle();
    chk("kr req", mem_bus.req, 1);
    chk("kr addr", mem_bus.addr, 'h200);
    tick();
    set_in(1,'h200,1, 0,0,0,0,0, 0,0,0); settle();
    chk("kr resp mem_req", mem_bus.req, 0);
    tick();
    idle_in(); settle(); tick();
    set_in(0,0,0, 0,0,0,0,0, 0,1,'hBAD0BAD0); settle(); tick();
    set_in(1,'h300,0, 0,0,0,0,0, 0,0,0); settle();
    chk("kr if_valid", if_valid, 0);
    chk("kr if_rdata", if_rdata, 'h22223333);
    chk("kr idle mem_req", mem_bus.req, 0);
    tick();
    set_in(1,'h300,0, 0,0,0,0,0, 1,0,0); settle();
    chk("kr next req", mem_bus.req, 1);
    chk("kr next addr", mem_bus.addr, 'h300);
    tick();
    set_in(1,'h300,0, 0,0,0,0,0, 0,1,'h00A00113); settle(); tick();
    set_in(1,'h300,0, 0,0,0,0,0, 0,0,0); settle();
    chk("kr next if_valid", if_valid, 1);
    chk("kr next if_rdata", if_rdata, 'h00A00113);
    tick();

    // kill in F_REQ
    set_in(1,'h400,0, 0,0,0,0,0, 0,0,0); settle(); tick();
    set_in(1,'h400,1, 0,0,0,0,0, 0,0,0); settle();
    chk("kq req", mem_bus.req, 1);
    tick();
    idle_in(); settle();
    chk("kq withdrawn", mem_bus.req, 0);
    chk("kq stall_f", stall_f, 0);
    tick();

    // back-to-back loads with ma_req held across ma_valid
    set_in(0,0,0, 1,0,'h10,0,4'hf, 0,0,0); settle(); tick();
    set_in(0,0,0, 1,0,'h10,0,4'hf, 1,0,0); settle();
    chk("bb req1 addr", mem_bus.addr, 'h10);
    tick();
    set_in(0,0,0, 1,0,'h10,0,4'hf, 0,1,'hAAAA0001); settle(); tick();
    set_in(0,0,0, 1,0,'h10,0,4'hf, 0,0,0); settle();
    chk("bb v1 ma_valid", ma_valid, 1);
    chk("bb v1 ma_rdata", ma_rdata, 'hAAAA0001);
    tick();
    set_in(0,0,0, 1,0,'h14,0,4'hf, 0,0,0); settle();
    chk("bb no reissue", mem_bus.req, 0);
    chk("bb v1 once", ma_valid, 0);
    chk("bb stall_m", stall_m, 1);
    tick();
    set_in(0,0,0, 1,0,'h14,0,4'hf, 1,0,0); settle();
    chk("bb req2", mem_bus.req, 1);
    chk("bb req2 addr", mem_bus.addr, 'h14);
    tick();
    set_in(0,0,0, 1,0,'h14,0,4'hf, 0,1,'hBBBB0002); settle(); tick();
    set_in(0,0,0, 1,0,'h14,0,4'hf, 0,0,0); settle();
    chk("bb v2 ma_valid", ma_valid, 1);
    chk("bb v2 ma_rdata", ma_rdata, 'hBBBB0002);
    tick();
    idle_in(); settle(); tick();

    // contention after a prior MA grant
`ifdef MEM_ARB_RR_EN
    win_a = 'h500; lose_a = 'h600; win_if = 1'b1;
`else
    win_a = 'h600; lose_a = 'h500; win_if = 1'b0;
`endif
    set_in(1,'h500,0, 1,0,'h600,0,4'hf, 0,0,0); settle(); tick();
    set_in(1,'h500,0, 1,0,'h600,0,4'hf, 1,0,0); settle();
    chk("arb win addr", mem_bus.addr, win_a);
    chk("arb win we", mem_bus.we, 0);
    tick();
    set_in(1,'h500,0, 1,0,'h600,0,4'hf, 0,1,'h0000C0DE); settle(); tick();
    set_in(1,'h500,0, 1,0,'h600,0,4'hf, 0,0,0); settle();
    chk("arb win if_valid", if_valid, win_if);
    chk("arb win ma_valid", ma_valid, !win_if);
    tick();
    set_in(1,'h500,0, 1,0,'h600,0,4'hf, 1,0,0); settle();
    chk("arb lose req", mem_bus.req, 1);
    chk("arb lose addr", mem_bus.addr, lose_a);
    tick();
    set_in(1,'h500,0, 1,0,'h600,0,4'hf, 0,1,'h0000F00D); settle(); tick();
    set_in(1,'h500,0, 1,0,'h600,0,4'hf, 0,0,0); settle();
    chk("arb lose if_valid", if_valid, !win_if);
    chk("arb lose ma_valid", ma_valid, win_if);
    tick();
    idle_in(); settle(); tick();

    // reset while in M_RESP, then a late rvalid
    set_in(0,0,0, 1,0,'h50,0,4'hf, 0,0,0); settle(); tick();
    set_in(0,0,0, 1,0,'h50,0,4'hf, 1,0,0); settle(); tick();
    idle_in();
    #2 rst_n = 1'b0;
    #1;
    chk("ar mem_req", mem_bus.req, 0);
    chk("ar mem_addr", mem_bus.addr, 0);
    chk("ar if_valid", if_valid, 0);
    chk("ar ma_valid", ma_valid, 0);
    chk("ar if_rdata", if_rdata, 0);
    chk("ar ma_rdata", ma_rdata, 0);
    chk("ar stall_m", stall_m, 0);
    tick();
    rst_n = 1'b1;
    set_in(0,0,0, 0,0,0,0,0, 0,1,'h0000DEAD); settle(); tick();
    idle_in(); settle();
    chk("ar late ma_valid", ma_valid, 0);
    chk("ar late ma_rdata", ma_rdata, 0);
    chk("ar late mem_req", mem_bus.req, 0);
    tick();

    // randomized traffic against the transaction-level model
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    m_busy = 0; m_who_ma = 0; m_granted = 0; m_killed = 0; m_ifv = 0; m_mav = 0;
    m_last_ma = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_be = 0; m_ifr = 0; m_mar = 0;
    if_act = 0; ma_act = 0; if_end = 0; ma_end = 0;
    for (int c = 0; c < 3000; c++) begin
      if (if_end) begin if_act = 0; if_end = 0; end
      if (!if_act && $urandom_range(0, 2) == 0) begin
        if_act = 1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if_req  = if_act;
      if_kill = if_act && ($urandom_range(0, 9) == 0);
      if (if_kill || m_ifv) if_end = 1;
      if (ma_end) begin ma_act = 0; ma_end = 0; end
      if (!ma_act && $urandom_range(0, 3) == 0) begin
        ma_act = 1; ma_we = $urandom_range(0, 1); ma_addr = $urandom;
        ma_wdata = $urandom; ma_be = 4'($urandom_range(1, 15));
      end
      ma_req = ma_act;
      if (m_mav) ma_end = 1;
      gnt = $urandom_range(0, 1); rvalid = ($urandom_range(0, 2) == 0); rdata = $urandom;
      settle();

      chk("rnd mem_req", mem_bus.req, m_busy && !m_granted);
      if (m_busy && !m_granted) begin
        chk("rnd mem_addr", mem_bus.addr, m_addr);
        chk("rnd mem_we", mem_bus.we, m_we);
        chk("rnd mem_be", mem_bus.be, m_be);
        if (m_we) chk("rnd mem_wdata", mem_bus.wdata, m_wdata);
      end
      chk("rnd if_valid", if_valid, m_ifv);
      chk("rnd ma_valid", ma_valid, m_mav);
      chk("rnd if_rdata", if_rdata, m_ifr);
      chk("rnd ma_rdata", ma_rdata, m_mar);
      chk("rnd stall_m", stall_m, ma_req && !m_mav);
      chk("rnd stall_f", stall_f, (if_req && !m_ifv) || (ma_req && !m_mav));
      chk("rnd valid overlap", if_valid & ma_valid, 0);

      n_ifv = 0; n_mav = 0;
      if (!m_busy) begin
        a_ma = ma_req && !m_mav;
        a_if = if_req && !m_ifv;
`ifdef MEM_ARB_RR_EN
        if (a_ma && a_if) take_ma = !m_last_ma;
        else              take_ma = a_ma;
`else
        take_ma = a_ma;
`endif
        if (take_ma) begin
          m_busy = 1; m_who_ma = 1; m_we = ma_we; m_addr = ma_addr;
          m_wdata = ma_wdata; m_be = ma_be; m_last_ma = 1;
        end else if (a_if) begin
          m_busy = 1; m_who_ma = 0; m_we = 0; m_addr = if_addr;
          m_wdata = 0; m_be = 4'hf; m_last_ma = 0;
        end
        m_granted = 0; m_killed = 0;
      end else if (!m_granted) begin
        if (gnt) begin
          m_granted = 1;
          if (!m_who_ma && if_kill) m_killed = 1;
        end else if (!m_who_ma && if_kill) begin
          m_busy = 0;
        end
      end else begin
        if (rvalid) begin
          m_busy = 0;
          if (m_who_ma) begin
            m_mar = rdata; n_mav = 1;
          end else if (!(m_killed || if_kill)) begin
            m_ifr = rdata; n_ifv = 1;
          end
        end else if (!m_who_ma && if_kill) begin
          m_killed = 1;
        end
      end
      m_ifv = n_ifv; m_mav = n_mav;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
